// File: rtl/jacobi_mem_pkg.sv
// Shared types and constants for the Jacobi solver V-vector memory.
package jacobi_mem_pkg;

  localparam int CPLX_W = 48;

  // One complex vector entry: real half on top, imaginary half below.
  typedef struct packed {
    logic [CPLX_W/2-1:0] re;
    logic [CPLX_W/2-1:0] im;
  } cplx_t;

  // 1.0 + j0 in the solver's fixed-point format.
  localparam logic [CPLX_W-1:0] INIT_ONE = 48'h400000_000000;

  // Ceiling log2 for sizing address fields from parameters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

endpackage

// File: rtl/vsram_bank.sv
// Single 1R1W bank: synchronous write, registered read, no internal bypass.
module vsram_bank
  import jacobi_mem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 48,
  localparam int ROW_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ROW_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ROW_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; contents are not reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to the same row returns the old word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vsram_banked_ctrl.sv
// Banked V-vector SRAM: two arbitrated read ports, one write port with
// write-to-read forwarding, and a hardware init sequencer.
//
// state | meaning
// IDLE  | normal operation, reads and writes arbitrated
// INIT  | writing INIT_VAL to row cnt of every bank, all ports blocked
module vsram_banked_ctrl
  import jacobi_mem_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 512,
  parameter int DATA_W     = 48,
  parameter int ADDR_W     = clog2(NUM_BANKS * BANK_DEPTH),
  parameter logic [DATA_W-1:0] INIT_VAL = INIT_ONE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_start,
  output logic              busy,
  output logic              init_done,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [15:0]       conflict_cnt
);

  localparam int BANK_BITS = clog2(NUM_BANKS);
  localparam int ROW_W     = ADDR_W - BANK_BITS;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_DEPTH - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  logic             init_done_d;

  logic [BANK_BITS-1:0] bank0, bank1, wbank;
  logic [ROW_W-1:0]     row0, row1, wrow;
  logic                 conflict;

  logic [NUM_BANKS-1:0] bank_re, bank_we;
  logic [ROW_W-1:0]     bank_raddr [NUM_BANKS];
  logic [ROW_W-1:0]     bank_waddr [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic [BANK_BITS-1:0] rd0_bank_q, rd1_bank_q;
  logic                 rd0_fwd_q, rd1_fwd_q;
  logic [DATA_W-1:0]    wdata_q, rd0_hold_q, rd1_hold_q;

  // FSM state, row counter and the registered init_done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= init_done_d;
    end
  end

  // Next-state logic; init_start is only honoured from IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == INIT);

  assign bank0 = rd0_addr[BANK_BITS-1:0];
  assign row0  = rd0_addr[ADDR_W-1:BANK_BITS];
  assign bank1 = rd1_addr[BANK_BITS-1:0];
  assign row1  = rd1_addr[ADDR_W-1:BANK_BITS];
  assign wbank = wr_addr[BANK_BITS-1:0];
  assign wrow  = wr_addr[ADDR_W-1:BANK_BITS];

  // Grants: port 0 has priority on a same-bank, different-row collision;
  // identical addresses share one bank read.
  always_comb begin
    conflict = rd0_req && rd1_req && (bank0 == bank1) && (row0 != row1);
    rd0_gnt  = rd0_req && !busy;
    rd1_gnt  = rd1_req && !busy && !conflict;
    wr_gnt   = wr_en && !busy;
  end

  // Saturating count of cycles where port 1 lost arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) conflict_cnt <= '0;
    else if (conflict && !busy && (conflict_cnt != 16'hFFFF))
      conflict_cnt <= conflict_cnt + 16'd1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_re[b]    = (rd0_gnt && (bank0 == BANK_BITS'(b))) ||
                           (rd1_gnt && (bank1 == BANK_BITS'(b)));
    assign bank_raddr[b] = (rd0_gnt && (bank0 == BANK_BITS'(b))) ? row0 : row1;
    assign bank_we[b]    = busy || (wr_gnt && (wbank == BANK_BITS'(b)));
    assign bank_waddr[b] = busy ? cnt_q : wrow;
    assign bank_wdata[b] = busy ? INIT_VAL : wr_data;

    vsram_bank #(
      .DEPTH (BANK_DEPTH),
      .DATA_W(DATA_W)
    ) u_bank (
      .clock(clock),
      .reset(reset),
      .we   (bank_we[b]),
      .waddr(bank_waddr[b]),
      .wdata(bank_wdata[b]),
      .re   (bank_re[b]),
      .raddr(bank_raddr[b]),
      .rdata(bank_rdata[b])
    );
  end

  // Read return tracking: which bank to select, whether to bypass with the
  // write data, and a hold copy so outputs stay put while valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd0_valid  <= 1'b0;
      rd1_valid  <= 1'b0;
      rd0_bank_q <= '0;
      rd1_bank_q <= '0;
      rd0_fwd_q  <= 1'b0;
      rd1_fwd_q  <= 1'b0;
      wdata_q    <= '0;
      rd0_hold_q <= '0;
      rd1_hold_q <= '0;
    end else begin
      rd0_valid  <= rd0_gnt;
      rd1_valid  <= rd1_gnt;
      rd0_bank_q <= bank0;
      rd1_bank_q <= bank1;
      rd0_fwd_q  <= rd0_gnt && wr_gnt && (rd0_addr == wr_addr);
      rd1_fwd_q  <= rd1_gnt && wr_gnt && (rd1_addr == wr_addr);
      if (wr_gnt) wdata_q <= wr_data;
      rd0_hold_q <= rd0_data;
      rd1_hold_q <= rd1_data;
    end
  end

  // Output data select from registered sources only.
  always_comb begin
    rd0_data = rd0_hold_q;
    rd1_data = rd1_hold_q;
    if (rd0_valid) rd0_data = rd0_fwd_q ? wdata_q : bank_rdata[rd0_bank_q];
    if (rd1_valid) rd1_data = rd1_fwd_q ? wdata_q : bank_rdata[rd1_bank_q];
  end

endmodule

// File: tb/tb_vsram_banked_ctrl.sv
// Self-checking bench for vsram_banked_ctrl against a flat-array memory model.
module tb_vsram_banked_ctrl;
  import jacobi_mem_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 512;
  localparam int WORDS = NB * DEPTH;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_start;
  logic        busy, init_done;
  logic        rd0_req, rd0_gnt, rd0_valid;
  logic [10:0] rd0_addr;
  logic [47:0] rd0_data;
  logic        rd1_req, rd1_gnt, rd1_valid;
  logic [10:0] rd1_addr;
  logic [47:0] rd1_data;
  logic        wr_en, wr_gnt;
  logic [10:0] wr_addr;
  logic [47:0] wr_data;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  logic [47:0] m_mem [WORDS];
  logic        m_v0, m_v1;
  logic [47:0] m_d0, m_d1;
  logic [15:0] m_cc;

  vsram_banked_ctrl dut (
    .clock(clock), .reset(reset), .init_start(init_start),
    .busy(busy), .init_done(init_done),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r0q, input logic [10:0] r0a,
                        input logic r1q, input logic [10:0] r1a,
                        input logic we, input logic [10:0] wa, input logic [47:0] wd);
    rd0_req = r0q; rd0_addr = r0a;
    rd1_req = r1q; rd1_addr = r1a;
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  task automatic model_init_all();
    for (int i = 0; i < WORDS; i++) m_mem[i] = INIT_ONE;
  endtask

  task automatic model_reset();
    m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0; m_cc = '0;
  endtask

  // One idle-mode cycle: grants checked mid-cycle, read returns after the edge.
  task automatic step();
    bit conf, g0, g1, gw;
    logic [47:0] n0, n1;
    @(negedge clock);
    conf = rd0_req && rd1_req && ((rd0_addr % NB) == (rd1_addr % NB)) &&
           (rd0_addr != rd1_addr);
    g0 = rd0_req;
    g1 = rd1_req && !conf;
    gw = wr_en;
    chk("rd0_gnt", 48'(rd0_gnt), 48'(g0));
    chk("rd1_gnt", 48'(rd1_gnt), 48'(g1));
    chk("wr_gnt", 48'(wr_gnt), 48'(gw));
    n0 = (gw && wr_addr == rd0_addr) ? wr_data : m_mem[rd0_addr];
    n1 = (gw && wr_addr == rd1_addr) ? wr_data : m_mem[rd1_addr];
    if (conf && m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
    @(posedge clock);
    if (gw) m_mem[wr_addr] = wr_data;
    m_v0 = g0; if (g0) m_d0 = n0;
    m_v1 = g1; if (g1) m_d1 = n1;
    #1;
    chk("rd0_valid", 48'(rd0_valid), 48'(m_v0));
    chk("rd1_valid", 48'(rd1_valid), 48'(m_v1));
    chk("rd0_data", rd0_data, m_d0);
    chk("rd1_data", rd1_data, m_d1);
    chk("conflict_cnt", 48'(conflict_cnt), 48'(m_cc));
  endtask

  // Pulse init_start and watch the whole run; optionally poke the ports and
  // re-pulse init_start while busy to confirm both are ignored.
  task automatic run_init(input bit noise, output int bc, output int dc);
    bc = 0; dc = 0;
    init_start = 1'b1;
    @(posedge clock); #1;
    init_start = 1'b0;
    if (noise) set_in(1'b1, 11'd3, 1'b1, 11'd7, 1'b1, 11'd11, 48'hFFFF_FFFF_FFFF);
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (busy) begin
        bc++;
        chk("busy_gnts", 48'({rd0_gnt, rd1_gnt, wr_gnt}), 48'd0);
      end
      if (init_done) dc++;
      if (noise && i == 10) set_in(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 11'd0, 48'd0);
      if (noise && i == 50) init_start = 1'b1;
      if (noise && i == 51) init_start = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int bc, dc;
    cplx_t v;
    logic [10:0] a0, a1, aw;

    reset = 1'b1; init_start = 1'b0;
    set_in(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 11'd0, 48'd0);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_init_done", 48'(init_done), 48'd0);
    chk("rst_rd0_valid", 48'(rd0_valid), 48'd0);
    chk("rst_rd1_valid", 48'(rd1_valid), 48'd0);
    chk("rst_rd0_data", rd0_data, 48'd0);
    chk("rst_rd1_data", rd1_data, 48'd0);
    chk("rst_conflict_cnt", 48'(conflict_cnt), 48'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_init(1'b1, bc, dc);
    chk("init_busy_cycles", 48'(bc), 48'd512);
    chk("init_done_pulses", 48'(dc), 48'd1);
    model_init_all();

    set_in(1'b1, 11'd0, 1'b1, 11'd1, 1'b0, 11'd0, 48'd0);
    step();
    chk("init_val_addr0", rd0_data, 48'h400000_000000);
    chk("init_val_addr1", rd1_data, 48'h400000_000000);
    set_in(1'b1, 11'd2047, 1'b1, 11'd1000, 1'b0, 11'd0, 48'd0);
    step();
    chk("init_val_addr2047", rd0_data, 48'h400000_000000);
    chk("init_val_addr1000", rd1_data, 48'h400000_000000);

    v.re = 24'h123456; v.im = 24'h654321;
    set_in(1'b0, 11'd0, 1'b0, 11'd0, 1'b1, 11'd5, v);
    step();
    set_in(1'b1, 11'd5, 1'b0, 11'd0, 1'b0, 11'd0, 48'd0);
    step();
    chk("wr_then_rd_valid", 48'(rd0_valid), 48'd1);
    chk("wr_then_rd_data", rd0_data, 48'h123456_654321);

    set_in(1'b0, 11'd0, 1'b1, 11'd9, 1'b1, 11'd9, 48'hAAAAAA_555555);
    step();
    chk("fwd_rd1_data", rd1_data, 48'hAAAAAA_555555);

    set_in(1'b1, 11'd4, 1'b1, 11'd8, 1'b0, 11'd0, 48'd0);
    step();
    chk("conflict_cnt_0to1", 48'(conflict_cnt), 48'd1);
    set_in(1'b0, 11'd4, 1'b1, 11'd8, 1'b0, 11'd0, 48'd0);
    step();
    chk("conflict_retry_valid", 48'(rd1_valid), 48'd1);

    set_in(1'b1, 11'd7, 1'b1, 11'd7, 1'b0, 11'd0, 48'd0);
    step();
    chk("broadcast_same_data", rd1_data, 48'h400000_000000);
    chk("broadcast_no_conflict", 48'(conflict_cnt), 48'd1);
    set_in(1'b1, 11'd1, 1'b1, 11'd2, 1'b0, 11'd0, 48'd0);
    step();

    for (int i = 0; i < 400; i++) begin
      a0 = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 15));
      aw = ($urandom_range(0, 2) == 0) ? a0 : 11'($urandom_range(0, 15));
      set_in(1'($urandom_range(0, 1)), a0, 1'($urandom_range(0, 1)), a1,
             1'($urandom_range(0, 1)), aw, {$urandom(), 16'($urandom())});
      step();
    end
    set_in(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 11'd0, 48'd0);

    init_start = 1'b1;
    @(posedge clock); #1;
    init_start = 1'b0;
    dc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (init_done) dc++;
    end
    chk("abort_busy_before_reset", 48'(busy), 48'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy_low", 48'(busy), 48'd0);
    chk("abort_rd0_data", rd0_data, 48'd0);
    chk("abort_conflict_cnt", 48'(conflict_cnt), 48'd0);
    @(posedge clock); #1;
    chk("abort_no_init_done_reset", 48'(init_done), 48'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    if (init_done) dc++;
    chk("abort_no_init_done", 48'(dc), 48'd0);
    @(posedge clock); #1;

    run_init(1'b0, bc, dc);
    chk("reinit_busy_cycles", 48'(bc), 48'd512);
    chk("reinit_done_pulses", 48'(dc), 48'd1);
    model_init_all();
    set_in(1'b1, 11'd9, 1'b1, 11'd1999, 1'b0, 11'd0, 48'd0);
    step();
    chk("reinit_val", rd0_data, 48'h400000_000000);
    set_in(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 11'd0, 48'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vsram_banked_ctrl.md
Name: vsram_banked_ctrl

Overview:
- Parametrised successor to the fixed four-bank V-vector SRAM arrangement in the Jacobi solver memory subsystem.
- Stores a complex vector of NUM_BANKS*BANK_DEPTH entries, each {real,img}, interleaved across NUM_BANKS 1R1W banks.
- Provides two arbitrated read ports and one write port, with write-to-read forwarding.
- Includes a hardware init sequencer that loads INIT_VAL into every entry before iteration starts.

Parameters:
- NUM_BANKS, 4, bank count; power of two, minimum 2.
- BANK_DEPTH, 512, entries per bank; power of two.
- DATA_W, 48, entry width: real in [DATA_W-1:DATA_W/2], img in [DATA_W/2-1:0].
- ADDR_W, log2(NUM_BANKS*BANK_DEPTH) = 11, global entry address width.
- INIT_VAL, 48'h400000_000000, value written by the init sequencer (1.0 + j0).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- init_start  in  1  one-cycle pulse that begins the init sequence.
- busy  out  1  high while the init sequence runs.
- init_done  out  1  one-cycle pulse after the last init write.
- rd0_req  in  1  port 0 read request.
- rd0_addr  in  ADDR_W  port 0 read address.
- rd0_gnt  out  1  port 0 request accepted this cycle (combinational).
- rd0_valid  out  1  port 0 data valid.
- rd0_data  out  DATA_W  port 0 read data.
- rd1_req, rd1_addr, rd1_gnt, rd1_valid, rd1_data: same as port 0, for port 1.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  write accepted this cycle (combinational).
- conflict_cnt  out  16  saturating count of port-1 stalls.

Behaviour:
- Address mapping: bank = addr[log2(NUM_BANKS)-1:0]; row = addr[ADDR_W-1:log2(NUM_BANKS)].
- Reset values: busy=0, init_done=0, rd0_valid=0, rd1_valid=0, rd0_data=0, rd1_data=0, conflict_cnt=0, FSM=IDLE. Bank contents are undefined after reset.
- State machine has two states:
  - IDLE: init_start goes to INIT with row counter cleared.
  - INIT: every cycle, write INIT_VAL to row=cnt in all banks in parallel and increment cnt. At cnt=BANK_DEPTH-1, write the last row, pulse init_done the next cycle, and return to IDLE. Total duration is BANK_DEPTH cycles of busy.
  - init_start while in INIT is ignored.
  - reset mid-INIT returns to IDLE, busy=0, no init_done pulse; contents are partially initialised.
- While busy=1: rd0_gnt, rd1_gnt and wr_gnt are all 0; requests are dropped and the requester must hold them.
- Read grant in IDLE:
  - rdN_gnt = rdN_req, except in the conflict case below.
  - Conflict (both requests, same bank, different row): port 0 wins; rd1_gnt=0; conflict_cnt increments and saturates at 16'hFFFF.
  - Both ports requesting the same address: both granted; one bank read is broadcast to both.
- Read latency is exactly one cycle. rdN_valid is high in the cycle after rdN_gnt, and rdN_data is registered. rdN_data holds its last value while rdN_valid=0.
- Write:
  - wr_gnt = wr_en & ~busy.
  - The bank is updated at the clock edge.
  - A write and a read never conflict; each bank is 1R1W.
- Forwarding: if a granted read has the same address as a granted write in the same cycle, rdN_data in the next cycle equals wr_data (new data), not the old bank content.
- A read one cycle after a write to the same address returns the written value from the bank.

Decomposition:
- Package jacobi_mem_pkg contains:
  - the cplx_t typedef (real/img halves, DATA_W/2 bits each);
  - the INIT_ONE constant (48'h400000_000000);
  - a clog2 helper function;
  - the FSM state enum {IDLE, INIT}.
- Sub-module vsram_bank:
  - single-bank 1R1W synchronous RAM with BANK_DEPTH x DATA_W storage;
  - one registered read port and one write port;
  - no forwarding inside the bank.
- Instantiate NUM_BANKS copies of vsram_bank with a generate loop.
- Arbitration, forwarding and the FSM stay in vsram_banked_ctrl.

Test Plan:
- Init: reset, then pulse init_start. Required: busy is high for exactly 512 cycles, init_done pulses once, and reading addresses 0, 1, 2047 and 1000 returns 48'h400000_000000.
- Write then read: write 48'h123456_654321 to addr 5 (bank 1, row 1), then read it on port 0 in the next cycle. Required: rd0_valid is high one cycle after the grant and rd0_data=48'h123456_654321.
- Forwarding: in the same cycle, write 48'hAAAAAA_555555 to addr 9 and read addr 9 on port 1. Required: rd1_data=48'hAAAAAA_555555 in the next cycle.
- Bank conflict: rd0_addr=4 and rd1_addr=8 (both bank 0, rows 1 and 2) requested together. Required: rd0_gnt=1, rd1_gnt=0, conflict_cnt goes 0→1. Port 1 holds the request and is granted in the next cycle.
- Broadcast and parallel reads:
  - Both ports read addr 7: both are granted and both return the same data with no conflict_cnt change.
  - rd0_addr=1 and rd1_addr=2 (different banks): both are granted.
- Init abort and blocking:
  - Pulse init_start, assert reset at cycle 100, release, then pulse init_start again. Required: busy goes low immediately on reset, no init_done pulse appears for the aborted run, and the second run completes after 512 cycles.
  - Requests presented during busy see all gnt=0.
